// File: rtl/btc_miner_sequencer.sv
// btc_miner_sequencer: hands one job at a time to NUM_CORES mining cores and
// collects their nonce finds, round-robin arbitrated, into a tagged result FIFO.
module btc_miner_sequencer #(
  parameter int NUM_CORES  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int JOB_ID_W   = 8
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         job_valid,
  input  logic [JOB_ID_W-1:0]          job_id,
  output logic                         job_ready,
  output logic                         core_start,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*32-1:0]      core_nonce,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [31:0]                  res_nonce,
  output logic [$clog2(NUM_CORES)-1:0] res_core,
  output logic [JOB_ID_W-1:0]          res_job_id,
  output logic                         busy,
  output logic                         job_done,
  output logic                         overflow,
  input  logic                         clr_overflow
);
  localparam int CW = $clog2(NUM_CORES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = JOB_ID_W + CW + 32;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CW-1:0] IDX_ONE = 1;

  // state | meaning
  // IDLE  | no job in flight, job_ready high
  // START | core_start pulse to all cores
  // GUARD | core_done ignored while cores clear a stale done
  // RUN   | waiting for every core to report done
  // DRAIN | waiting for all pending finds to reach the FIFO
  typedef enum logic [2:0] {S_IDLE, S_START, S_GUARD, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic                r_job_ready;
  logic                r_core_start;
  logic                r_busy;
  logic                r_job_done;
  logic                r_overflow;
  logic [JOB_ID_W-1:0] r_cur_id;

  logic [NUM_CORES-1:0] r_found_q;
  logic [NUM_CORES-1:0] r_pend;
  logic [CW-1:0]        r_rr_ptr;
  logic [31:0]          r_cap [NUM_CORES];

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  logic                 w_rec_en;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [NUM_CORES-1:0] w_rec;
  logic [NUM_CORES-1:0] w_clr;
  logic [NUM_CORES-1:0] w_lost;
  logic [CW-1:0]        w_gnt_idx;
  logic [CW-1:0]        w_cand;
  logic [EW-1:0]        w_head;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= S_IDLE;
      r_job_ready  <= 1'b1;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_job_done   <= 1'b0;
      r_cur_id     <= '0;
    end else begin
      r_core_start <= 1'b0;
      r_job_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_cur_id     <= job_id;
            r_state      <= S_START;
            r_job_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_core_start <= 1'b1;
          end
        end
        S_START: r_state <= S_GUARD;
        S_GUARD: r_state <= S_RUN;
        S_RUN: begin
          if (&core_done) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_pend == '0) begin
            r_state     <= S_IDLE;
            r_job_done  <= 1'b1;
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_job_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign w_rec_en = (r_state == S_START) || (r_state == S_GUARD) || (r_state == S_RUN);
  assign w_rec    = core_found & ~r_found_q & {NUM_CORES{w_rec_en}};

  // Round-robin search from r_rr_ptr; wrap comes free since NUM_CORES is a power of 2.
  always_comb begin
    w_push    = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (!w_full) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        w_cand = r_rr_ptr + CW'(k);
        if (!w_push && r_pend[w_cand]) begin
          w_push    = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_push) w_clr[w_gnt_idx] = 1'b1;
  end

  // A find is lost only if its slot stays occupied through this cycle.
  assign w_lost = w_rec & r_pend & ~w_clr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_found_q  <= '0;
      r_pend     <= '0;
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_found_q <= core_found;
      r_pend    <= (r_pend & ~w_clr) | w_rec;
      if (w_push) r_rr_ptr <= w_gnt_idx + IDX_ONE;
      if (|w_lost) r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_rec[i] && !w_lost[i]) r_cap[i] <= core_nonce[32*i +: 32];
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && res_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_cur_id, w_gnt_idx, r_cap[w_gnt_idx]};
  end

  // Head is masked when empty so stale storage never shows after a flush.
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  assign res_valid  = !w_empty;
  assign res_nonce  = w_head[31:0];
  assign res_core   = w_head[32 +: CW];
  assign res_job_id = w_head[32+CW +: JOB_ID_W];

  assign job_ready  = r_job_ready;
  assign core_start = r_core_start;
  assign busy       = r_busy;
  assign job_done   = r_job_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_btc_miner_sequencer.sv
// Directed bench for btc_miner_sequencer: job flow, find capture, round-robin
// order, backpressure, overflow and mid-job reset.
module tb_btc_miner_sequencer;
  localparam int NC = 8;
  localparam int FD = 4;
  localparam int JW = 8;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              job_valid;
  logic [JW-1:0]     job_id;
  logic              job_ready;
  logic              core_start;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_found;
  logic [NC*32-1:0]  core_nonce;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_nonce;
  logic [2:0]        res_core;
  logic [JW-1:0]     res_job_id;
  logic              busy;
  logic              job_done;
  logic              overflow;
  logic              clr_overflow;

  btc_miner_sequencer #(.NUM_CORES(NC), .FIFO_DEPTH(FD), .JOB_ID_W(JW)) dut (
    .clk(clk), .arst_n(arst_n),
    .job_valid(job_valid), .job_id(job_id), .job_ready(job_ready),
    .core_start(core_start), .core_done(core_done), .core_found(core_found),
    .core_nonce(core_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
    .res_core(res_core), .res_job_id(res_job_id),
    .busy(busy), .job_done(job_done), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_done   = 0;

  int            q_core[$];
  logic [31:0]   q_nonce[$];
  logic [JW-1:0] q_id[$];

  always @(negedge clk) begin
    if (core_start) n_start++;
    if (job_done)   n_done++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nonce(input int i, input logic [31:0] v);
    core_nonce[32*i +: 32] = v;
  endtask

  task automatic expect_res(input int c, input logic [31:0] n, input logic [JW-1:0] id);
    q_core.push_back(c);
    q_nonce.push_back(n);
    q_id.push_back(id);
  endtask

  task automatic start_job(input logic [JW-1:0] id);
    int k = 0;
    job_id    = id;
    job_valid = 1'b1;
    while (!job_ready && k < 50) begin
      tick();
      k++;
    end
    check("accept_ready", job_ready, 1);
    core_done = '0;
    tick();
    job_valid = 1'b0;
    check("start_pulse", core_start, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic drain_check(input string tag);
    int n = 0;
    res_ready = 1'b1;
    while (q_core.size() > 0 && n < 40) begin
      if (res_valid) begin
        check({tag, "_core"},  res_core,   q_core[0]);
        check({tag, "_nonce"}, res_nonce,  q_nonce[0]);
        check({tag, "_id"},    res_job_id, q_id[0]);
        void'(q_core.pop_front());
        void'(q_nonce.pop_front());
        void'(q_id.pop_front());
      end
      tick();
      n++;
    end
    res_ready = 1'b0;
    check({tag, "_left"}, q_core.size(), 0);
  endtask

  task automatic wait_done(input string tag, input int base);
    int k = 0;
    core_done = '1;
    while (n_done == base && k < 30) begin
      tick();
      k++;
    end
    tick();
    check({tag, "_done_cnt"}, n_done - base, 1);
    check({tag, "_ready"}, job_ready, 1);
  endtask

  int s0;
  int d0;

  initial begin
    arst_n = 1'b0; job_valid = 1'b0; job_id = '0; core_done = '0; core_found = '0;
    core_nonce = '0; res_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) tick();
    check("rst_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", core_start, 0);
    check("rst_valid", res_valid, 0);
    check("rst_nonce", res_nonce, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", job_done, 0);
    arst_n = 1'b1;
    tick();

    // Job A: no finds, done 10 cycles after start
    s0 = n_start;
    start_job(8'h5A);
    repeat (10) tick();
    core_done = '1;
    tick();
    check("a_done_early", job_done, 0);
    tick();
    check("a_done", job_done, 1);
    check("a_ready", job_ready, 1);
    check("a_busy", busy, 0);
    tick();
    check("a_done_pulse", job_done, 0);
    check("a_start_cnt", n_start - s0, 1);
    check("a_fifo_empty", res_valid, 0);

    // Job B: single find on core 3
    set_nonce(3, 32'h6000_0123);
    start_job(8'h5A);
    tick();
    core_found[3] = 1'b1;
    tick();
    check("b_lat1", res_valid, 0);
    tick();
    check("b_lat2", res_valid, 1);
    d0 = n_done;
    expect_res(3, 32'h6000_0123, 8'h5A);
    drain_check("b");
    core_found = '0;
    wait_done("b", d0);

    // Job C: core 5 moves rr_ptr to 6, then 0/5/7 together -> 7,0,5
    set_nonce(5, 32'h5555_0001);
    start_job(8'h11);
    core_found[5] = 1'b1;
    expect_res(5, 32'h5555_0001, 8'h11);
    drain_check("c1");
    core_found[5] = 1'b0;
    tick();
    set_nonce(0, 32'h0000_00C0);
    set_nonce(5, 32'h5555_0002);
    set_nonce(7, 32'h7777_0007);
    core_found = 8'b1010_0001;
    d0 = n_done;
    expect_res(7, 32'h7777_0007, 8'h11);
    expect_res(0, 32'h0000_00C0, 8'h11);
    expect_res(5, 32'h5555_0002, 8'h11);
    drain_check("c2");
    core_found = '0;
    wait_done("c", d0);

    // Job D: backpressure with six finds, then overflow on core 2
    for (int i = 0; i < NC; i++) set_nonce(i, 32'hD000_0000 | i);
    start_job(8'h22);
    core_found = 8'b0111_1011;
    repeat (6) tick();
    check("d_valid", res_valid, 1);
    check("d_head_core", res_core, 6);
    check("d_ovf0", overflow, 0);
    set_nonce(2, 32'h2222_AAAA);
    core_found[2] = 1'b1;
    tick();
    set_nonce(2, 32'h2222_BBBB);
    core_found[2] = 1'b0;
    tick();
    core_found[2] = 1'b1;
    tick();
    check("d_ovf1", overflow, 1);
    core_done = '1;
    d0 = n_done;
    repeat (6) tick();
    check("d_hold_done", n_done - d0, 0);
    check("d_hold_busy", busy, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("d_clr", overflow, 0);
    expect_res(6, 32'hD000_0006, 8'h22);
    expect_res(0, 32'hD000_0000, 8'h22);
    expect_res(1, 32'hD000_0001, 8'h22);
    expect_res(3, 32'hD000_0003, 8'h22);
    expect_res(4, 32'hD000_0004, 8'h22);
    expect_res(5, 32'hD000_0005, 8'h22);
    expect_res(2, 32'h2222_AAAA, 8'h22);
    drain_check("d");
    core_found = '0;
    wait_done("d", d0);

    // Job G: stale done held high -> earliest job_done at T+5
    start_job(8'h66);
    core_done = '1;
    repeat (3) tick();
    check("g_t4", job_done, 0);
    tick();
    check("g_t5", job_done, 1);
    tick();

    // Job E: reset during RUN with two FIFO entries
    set_nonce(1, 32'h1111_0001);
    set_nonce(2, 32'h2222_0002);
    start_job(8'h33);
    core_found = 8'b0000_0110;
    repeat (5) tick();
    check("e_pre_valid", res_valid, 1);
    check("e_pre_busy", busy, 1);
    arst_n = 1'b0;
    #1;
    check("e_rst_ready", job_ready, 1);
    check("e_rst_busy", busy, 0);
    check("e_rst_valid", res_valid, 0);
    check("e_rst_nonce", res_nonce, 0);
    check("e_rst_core", res_core, 0);
    check("e_rst_id", res_job_id, 0);
    tick();
    arst_n = 1'b1;
    core_found = '0;
    tick();
    check("e_post_valid", res_valid, 0);

    // Job F: normal job after the abort
    set_nonce(7, 32'hF7F7_0007);
    start_job(8'h44);
    core_found[7] = 1'b1;
    d0 = n_done;
    expect_res(7, 32'hF7F7_0007, 8'h44);
    drain_check("f");
    core_found = '0;
    wait_done("f", d0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
